// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle signed adder/subtractor.
// The operation is started with start. Operand A and operand B (B is inverted
// for subtract) are captured on that edge. Each RUN cycle then adds one
// CHUNK-bit slice, starting from the least significant slice, with a rippled
// carry. The result and the flags are published only on the completion edge.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst_n  - synchronous active-low reset
//   start  - request; ignored while busy
//   op     - 0 = a + b, 1 = a - b
//   a, b   - WIDTH-bit two's-complement operands
//   busy   - high while the chunks are being summed (RUN)
//   done   - one-cycle completion pulse (DONE)
//   out    - result of the last completed operation
//   cf     - {OF, SF, ZF} of the last completed operation
//   cout   - carry out of the MSB of the last completed operation
//
// state | meaning
// IDLE  | waiting for start
// RUN   | summing chunk k_q; result published with the last chunk
// DONE  | done pulse; start here chains the next operation directly

module add_sub_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       cf,
    output logic             cout
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             msb_cin;
    logic [WIDTH-1:0] full_sum;
    logic             last_chunk;
    logic             capture;

    always_comb begin
        a_chunk = a_q[k_q*CHUNK +: CHUNK];
        b_chunk = b_q[k_q*CHUNK +: CHUNK];
        {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                + {{CHUNK{1'b0}}, carry_q};
        // Carry into the MSB. This value is meaningful only on the last chunk,
        // which holds the MSB.
        msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        // The final result is the stored lower chunks plus the slice being
        // summed now. The flags are therefore taken from the full word and
        // never from a partial result.
        full_sum = part_q;
        full_sum[k_q*CHUNK +: CHUNK] = chunk_sum;
        last_chunk = (k_q == K_LAST);
        capture = start && (state_q != RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            out     <= '0;
            cf      <= 3'b000;
            cout    <= 1'b0;
        end else if (capture) begin
            // Subtraction is a + ~b + 1. The +1 enters as the initial carry.
            a_q     <= a;
            b_q     <= op ? ~b : b;
            carry_q <= op;
            k_q     <= '0;
        end else if (state_q == RUN) begin
            part_q[k_q*CHUNK +: CHUNK] <= chunk_sum;
            carry_q <= chunk_cout;
            k_q     <= k_q + 1'b1;
            if (last_chunk) begin
                out  <= full_sum;
                cout <= chunk_cout;
                cf   <= {msb_cin ^ chunk_cout, full_sum[WIDTH-1], full_sum == '0};
            end
        end
    end

endmodule

// File: tb/tb_add_sub_seq.sv
module tb_add_sub_seq;

    typedef struct packed {
        logic [63:0] out;
        logic [2:0]  cf;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        start0, op0;
    logic [63:0] a0, b0, out0;
    logic        busy0, done0, cout0;
    logic [2:0]  cf0;

    logic        start1, op1;
    logic [31:0] a1, b1, out1;
    logic        busy1, done1, cout1;
    logic [2:0]  cf1;

    logic        start2, op2;
    logic [63:0] a2, b2, out2;
    logic        busy2, done2, cout2;
    logic [2:0]  cf2;

    add_sub_seq #(.WIDTH(64), .CHUNK(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op(op0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .out(out0), .cf(cf0), .cout(cout0)
    );

    add_sub_seq #(.WIDTH(32), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .out(out1), .cf(cf1), .cout(cout1)
    );

    add_sub_seq #(.WIDTH(64), .CHUNK(64)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .out(out2), .cf(cf2), .cout(cout2)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t cur0, last0, m0, m1, m2;
    int   cnt1, cnt2;
    logic [63:0] rx, ry;
    logic        ro;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full-width reference. Overflow is taken from the operand signs and the
    // result sign, not from carries.
    function automatic exp_t ref_model(input int w, input logic o,
                                       input logic [63:0] x, input logic [63:0] y);
        exp_t        r;
        logic [63:0] mask, xa, yb, res;
        logic [64:0] s;
        logic        am, bm, rm, of;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        xa   = x & mask;
        yb   = (o ? ~y : y) & mask;
        s    = {1'b0, xa} + {1'b0, yb} + {64'd0, o};
        res  = s[63:0] & mask;
        am   = xa[w-1];
        bm   = y[w-1];
        rm   = res[w-1];
        of   = o ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
        r.out  = res;
        r.cf   = {of, rm, (res == 64'd0)};
        r.cout = s[w];
        return r;
    endfunction

    // Scoreboard monitors. Each monitor pops one expected entry per done pulse.
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut0_spurious_done: got done=1 expected no pending op");
            end else begin
                m0 = q0.pop_front();
                check("dut0_out", out0, m0.out);
                check("dut0_cf", {61'd0, cf0}, {61'd0, m0.cf});
                check("dut0_cout", {63'd0, cout0}, {63'd0, m0.cout});
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut1_spurious_done: got done=1 expected no pending op");
            end else begin
                m1 = q1.pop_front();
                check("dut1_out", {32'd0, out1}, m1.out);
                check("dut1_cf", {61'd0, cf1}, {61'd0, m1.cf});
                check("dut1_cout", {63'd0, cout1}, {63'd0, m1.cout});
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut2_spurious_done: got done=1 expected no pending op");
            end else begin
                m2 = q2.pop_front();
                check("dut2_out", out2, m2.out);
                check("dut2_cf", {61'd0, cf2}, {61'd0, m2.cf});
                check("dut2_cout", {63'd0, cout2}, {63'd0, m2.cout});
            end
        end
    end

    task automatic issue0(input logic o, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] eo, input logic [2:0] ecf, input logic ec);
        cur0.out  = eo;
        cur0.cf   = ecf;
        cur0.cout = ec;
        q0.push_back(cur0);
        op0    = o;
        a0     = x;
        b0     = y;
        start0 = 1'b1;
    endtask

    // Waits for done. Checks that out and cf hold their previous values while
    // busy. With disturb set, it re-pulses start and scrambles the inputs
    // mid-flight.
    task automatic wait0(input bit disturb);
        int cnt  = 0;
        bit seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) start0 = 1'b0;
            if (disturb && cnt == 2) begin
                start0 = 1'b1;
                a0     = {$urandom, $urandom};
                b0     = {$urandom, $urandom};
                op0    = ~op0;
            end
            if (disturb && cnt == 3) start0 = 1'b0;
            if (busy0) begin
                check("dut0_out_hold", out0, last0.out);
                check("dut0_cf_hold", {61'd0, cf0}, {61'd0, last0.cf});
            end
            if (done0) seen = 1;
        end
        check("dut0_latency", 64'(cnt), 64'd5);
        last0 = cur0;
    endtask

    task automatic do0(input logic o, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] eo, input logic [2:0] ecf, input logic ec,
                       input bit disturb);
        issue0(o, x, y, eo, ecf, ec);
        wait0(disturb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; op0 = 1'b0; a0 = '0; b0 = '0;
        start1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0;
        start2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0;
        last0  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy0}, 64'd0);
        check("rst_done", {63'd0, done0}, 64'd0);
        check("rst_out", out0, 64'd0);
        check("rst_cf", {61'd0, cf0}, 64'd0);
        check("rst_cout", {63'd0, cout0}, 64'd0);
        check("rst_dut1_out", {32'd0, out1}, 64'd0);
        check("rst_dut2_busy", {63'd0, busy2}, 64'd0);
        rst_n = 1'b1;

        fork
            begin
                do0(1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 3'b001, 1'b1, 0);
                do0(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b110, 1'b0, 0);
                do0(1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100, 1'b1, 0);
                do0(1'b1, 64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 1'b0, 0);
                do0(1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 3'b000, 1'b0, 1);
                do0(1'b1, 64'd5, 64'd5, 64'd0, 3'b001, 1'b1, 0);
                do0(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 1'b1, 0);
                do0(1'b1, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b110, 1'b0, 0);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    if (i == 0) begin
                        rx = 64'h7FFF_FFFF; ry = 64'd1; ro = 1'b0;
                    end else if (i == 1) begin
                        rx = 64'h8000_0000; ry = 64'd1; ro = 1'b1;
                    end else if (i == 2) begin
                        rx = 64'h0000_00FF; ry = 64'd1; ro = 1'b0;
                    end else begin
                        rx = {32'd0, $urandom}; ry = {32'd0, $urandom}; ro = 1'($urandom_range(0, 1));
                    end
                    a1 = rx[31:0]; b1 = ry[31:0]; op1 = ro; start1 = 1'b1;
                    q1.push_back(ref_model(32, ro, rx, ry));
                    cnt1 = 0;
                    @(negedge clk);
                    cnt1++;
                    while (!done1 && cnt1 < 20) begin
                        @(negedge clk);
                        cnt1++;
                    end
                    check("dut1_interval", 64'(cnt1), 64'd5);
                end
                start1 = 1'b0;
                @(negedge clk);
            end
            begin
                for (int j = 0; j < 12; j++) begin
                    a2 = {$urandom, $urandom};
                    b2 = {$urandom, $urandom};
                    op2 = 1'($urandom_range(0, 1));
                    if (j == 0) begin
                        a2 = 64'h7FFF_FFFF_FFFF_FFFF; b2 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 1'b1;
                    end
                    start2 = 1'b1;
                    q2.push_back(ref_model(64, op2, a2, b2));
                    cnt2 = 0;
                    @(negedge clk);
                    cnt2++;
                    while (!done2 && cnt2 < 20) begin
                        @(negedge clk);
                        cnt2++;
                    end
                    check("dut2_interval", 64'(cnt2), 64'd2);
                end
                start2 = 1'b0;
                @(negedge clk);
            end
        join

        // Abort in the second RUN cycle.
        @(negedge clk);
        start0 = 1'b1; a0 = 64'd1; b0 = 64'd2; op0 = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        check("abort_busy_before", {63'd0, busy0}, 64'd1);
        check("abort_out_hold", out0, last0.out);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy0}, 64'd0);
        check("abort_done", {63'd0, done0}, 64'd0);
        check("abort_out", out0, 64'd0);
        check("abort_cf", {61'd0, cf0}, 64'd0);
        check("abort_cout", {63'd0, cout0}, 64'd0);
        last0 = '0;

        // A start held through reset is taken on the first edge out of reset.
        issue0(1'b0, 64'd10, 64'd20, 64'd30, 3'b000, 1'b0);
        @(negedge clk);
        check("rst_start_ignored", {63'd0, busy0}, 64'd0);
        rst_n = 1'b1;
        wait0(0);

        @(negedge clk);
        @(negedge clk);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q2_drained", 64'(q2.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/add_sub_seq.md
ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits summed per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request; sampled only when not busy.
REQ-006 op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-007 a  input  WIDTH  signed two's-complement operand A.
REQ-008 b  input  WIDTH  signed two's-complement operand B.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 out  output  WIDTH  registered result of the last completed operation.
REQ-012 cf  output  3  registered condition flags: [0] ZF (out == 0), [1] SF (out MSB), [2] OF (signed overflow).
REQ-013 cout  output  1  registered carry out of the MSB of the last completed operation.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE with start=1, SHALL capture a, op, and b (or ~b when op=1), set carry-in to op, clear chunk index, and enter RUN.
REQ-016 In IDLE with start=0, SHALL stay in IDLE; in DONE with start=0, SHALL go to IDLE.
REQ-017 In RUN, each cycle SHALL add chunk k of the captured operands plus the running carry, store the CHUNK sum bits in an internal partial-result register, update the running carry, and increment k.
REQ-018 On the RUN cycle that processes chunk N-1, SHALL load out with the full sum, load cout with the final carry, update cf, assert done for the next cycle, and enter DONE.
REQ-019 Latency: done SHALL be high in the cycle following the N-th rising edge after the edge that sampled start (default: start sampled at edge 0, done high after edge 4).
REQ-020 OF SHALL equal carry into MSB XOR carry out of MSB; for subtraction, equivalently (a[MSB] != b[MSB]) and (out[MSB] != a[MSB]).
REQ-021 ZF and SF SHALL be derived from the final WIDTH-bit result, never from a partial result.
REQ-022 out, cf and cout SHALL hold their previous values throughout RUN and change only on the completion edge.
REQ-023 start asserted during RUN SHALL be ignored; the operation in flight SHALL complete unchanged.
REQ-024 Changes to a, b or op after the capture edge SHALL NOT affect the operation in flight.
REQ-025 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE.
REQ-026 start asserted in DONE SHALL begin a new operation back-to-back, with no IDLE cycle in between.
REQ-027 When CHUNK == WIDTH (N=1), the block SHALL complete in one RUN cycle with identical flag semantics.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, out=0, cf=3'b000, cout=0, and clear the chunk index, carry and partial result.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse and no update of out/cf beyond the reset values.
REQ-030 start held high during reset SHALL be ignored; it SHALL be sampled on the first edge with rst_n=1.

Verification
REQ-031 Default params, add a=5, b=-5 -> after 4 RUN cycles done=1, out=0, cf=3'b001, cout=1.
REQ-032 Add a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> out=64'h8000_0000_0000_0000, cf=3'b110, cout=0.
REQ-033 Subtract a=64'h8000_0000_0000_0000, b=1 -> out=64'h7FFF_FFFF_FFFF_FFFF, cf=3'b100; subtract a=3, b=7 -> out=-4, cf=3'b010.
REQ-034 Carry across chunks: a=64'h0000_0000_0000_FFFF, b=1 -> out=64'h0000_0000_0001_0000, cf=3'b000; start re-pulsed and a/b changed during RUN -> same result, single done pulse.
REQ-035 rst_n=0 on the 2nd RUN cycle -> no done pulse, out=0, cf=0, busy=0; the next start completes normally.
REQ-036 Randomised back-to-back ops with start held high in DONE for WIDTH=32, CHUNK=8 and WIDTH=64, CHUNK=64 -> every result and flag matches a reference model, done every N+1 cycles.
